// File: rtl/seg7_scan_driver_pkg.sv
// Shared 7-segment definitions: active-low glyphs for the common-anode display.
package seg7_scan_driver_pkg;

   localparam logic ACTIVE_LOW_ON  = 1'b0;
   localparam logic ACTIVE_LOW_OFF = 1'b1;

   // {g,f,e,d,c,b,a}, 0 = segment lit
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational nibble-to-glyph decoder; mode = 1 shows A..F as a dash (BCD range error).
module hex_to_seg7
   import seg7_scan_driver_pkg::*;
(
   input  logic [3:0] d,
   input  logic       mode,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (d)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = mode ? SEG_DASH : SEG_A;
         4'hB: seg = mode ? SEG_DASH : SEG_B;
         4'hC: seg = mode ? SEG_DASH : SEG_C;
         4'hD: seg = mode ? SEG_DASH : SEG_D;
         4'hE: seg = mode ? SEG_DASH : SEG_E;
         4'hF: seg = mode ? SEG_DASH : SEG_F;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver: slot scan with guard gap, per-frame
// input snapshot, leading-zero blanking and done-flag blinking.
module seg7_scan_driver
   import seg7_scan_driver_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 100000,
   parameter int GUARD        = 16,
   parameter int BLINK_FRAMES = 128
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   done,
   input  logic                    mode,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int SW = $clog2(NUM_DIGITS);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [DW-1:0]         div_cnt;
   logic [SW-1:0]         slot;
   logic [FW-1:0]         frame_cnt;
   logic                  blink_ph;
   logic                  init_pend;
   logic [3:0]            snap_d [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] snap_done;
   logic [NUM_DIGITS-1:0] snap_dp;

   logic                  div_wrap;
   logic                  frame_end;
   logic                  in_guard;
   logic [3:0]            cur_d [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] cur_done;
   logic [NUM_DIGITS-1:0] cur_dp;
   logic [NUM_DIGITS-1:0] lz_vec;
   logic                  blank;
   logic [6:0]            glyph;
   logic [NUM_DIGITS-1:0] an_d;
   logic [6:0]            seg_d;
   logic                  dp_d;

   assign div_wrap  = (div_cnt == DW'(SCAN_DIV - 1));
   assign frame_end = div_wrap && (slot == SW'(NUM_DIGITS - 1));

   generate
      if (GUARD == 0) begin : g_no_guard
         assign in_guard = 1'b0;
      end else begin : g_guard
         assign in_guard = (div_cnt < DW'(GUARD));
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt   <= '0;
         slot      <= '0;
         frame_cnt <= '0;
         blink_ph  <= 1'b0;
         init_pend <= 1'b1;
      end else begin
         init_pend <= 1'b0;
         div_cnt   <= div_wrap ? '0 : div_cnt + 1'b1;
         if (div_wrap)
            slot <= (slot == SW'(NUM_DIGITS - 1)) ? '0 : slot + 1'b1;
         if (frame_end) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
               frame_cnt <= '0;
               blink_ph  <= ~blink_ph;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

   // Snapshot is taken on the edge that enters slot 0, so a frame never mixes old and new inputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) snap_d[i] <= '0;
         snap_done <= '0;
         snap_dp   <= '0;
      end else if (init_pend || frame_end) begin
         for (int i = 0; i < NUM_DIGITS; i++) snap_d[i] <= digits[4*i +: 4];
         snap_done <= done;
         snap_dp   <= dp_mask;
      end
   end

   // The first cycle after reset already belongs to frame 0, so it sees the inputs being captured.
   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++)
         cur_d[i] = init_pend ? digits[4*i +: 4] : snap_d[i];
      cur_done = init_pend ? done    : snap_done;
      cur_dp   = init_pend ? dp_mask : snap_dp;
   end

   always_comb begin
      logic run;
      run    = 1'b1;
      lz_vec = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run       = run && (cur_d[i] == 4'h0);
         lz_vec[i] = run;
      end
   end

   hex_to_seg7 u_dec (
      .d    (cur_d[slot]),
      .mode (mode),
      .seg  (glyph)
   );

   assign blank = (blank_lz && (slot != '0) && lz_vec[slot]) ||
                  (cur_done[slot] && blink_ph);

   always_comb begin
      an_d  = {NUM_DIGITS{ACTIVE_LOW_OFF}};
      seg_d = SEG_BLANK;
      dp_d  = ACTIVE_LOW_OFF;
      if (!in_guard) begin
         an_d[slot] = ACTIVE_LOW_ON;
         if (!blank) begin
            seg_d = glyph;
            dp_d  = ~cur_dp[slot];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         an  <= {NUM_DIGITS{ACTIVE_LOW_OFF}};
         seg <= SEG_BLANK;
         dp  <= ACTIVE_LOW_OFF;
      end else begin
         an  <= an_d;
         seg <= seg_d;
         dp  <= dp_d;
      end
   end

endmodule
